// File: rtl/acc_ctrl_param.sv
// acc_ctrl_param -- 3-stage adaptive cruise controller: capture, gap/error compute, FSM with ramped outputs.
// Rev 1.0
`default_nettype none

module acc_ctrl_param #(
  parameter int SPEED_W    = 16,
  parameter int DIST_W     = 16,
  parameter int OUT_W      = 8,
  parameter int MIN_GAP    = 20,
  parameter int TIME_GAP   = 1,
  parameter int EMERG_DIST = 15,
  parameter int RAMP_STEP  = 8,
  parameter int KP_SHIFT   = 2,
  parameter int KB_SHIFT   = 1,
  parameter int EMERG_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] set_speed,
  input  logic [SPEED_W-1:0] vehicle_speed,
  input  logic [SPEED_W-1:0] lead_vehicle_speed,
  input  logic               lead_present,
  input  logic [DIST_W-1:0]  distance_to_lead,
  output logic [OUT_W-1:0]   throttle_out,
  output logic [OUT_W-1:0]   brake_out,
  output logic               out_valid,
  output logic [2:0]         state,
  output logic               emergency
);

  localparam int GW  = SPEED_W + 34;
  localparam int BW0 = (SPEED_W > DIST_W) ? SPEED_W : DIST_W;
  localparam int BW1 = (BW0 > OUT_W) ? BW0 : OUT_W;
  localparam int MW  = BW1 + KP_SHIFT + KB_SHIFT + 2;
  localparam int RW  = OUT_W + 33;
  localparam int HW  = (EMERG_HOLD > 1) ? $clog2(EMERG_HOLD) + 1 : 1;
  localparam logic [OUT_W-1:0] OUT_MAX  = '1;
  localparam logic [GW-1:0]    DIST_MAX = {{(GW-DIST_W){1'b0}}, {DIST_W{1'b1}}};
  localparam logic [1:0]       MODE_OFF   = 2'd0;
  localparam logic [1:0]       MODE_SPEED = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRUISE = 3'd1,
    ST_FOLLOW = 3'd2,
    ST_BRAKE  = 3'd3,
    ST_EMERG  = 3'd4
  } state_t;

  function automatic logic [OUT_W-1:0] sat(input logic [MW-1:0] x);
    return (x > MW'(OUT_MAX)) ? OUT_MAX : x[OUT_W-1:0];
  endfunction

  // Step toward tgt by at most RAMP_STEP, landing exactly on tgt when close enough.
  function automatic logic [OUT_W-1:0] ramp(input logic [OUT_W-1:0] cur, input logic [OUT_W-1:0] tgt);
    logic [RW-1:0] c, t, step, nv;
    c    = RW'(cur);
    t    = RW'(tgt);
    step = RW'(RAMP_STEP);
    nv   = t;
    if (t > c) begin
      if (t - c > step) nv = c + step;
    end else if (c > t) begin
      if (c - t > step) nv = c - step;
    end
    return nv[OUT_W-1:0];
  endfunction

  // Stage 1: capture
  logic               s1_valid;
  logic [1:0]         s1_mode;
  logic [SPEED_W-1:0] s1_set, s1_veh, s1_lead;
  logic               s1_lp;
  logic [DIST_W-1:0]  s1_dist;

  // Stage 2: gap and error
  logic               s2_valid;
  logic               s2_off, s2_lc;
  logic [SPEED_W-1:0] s2_set, s2_veh, s2_lead;
  logic [DIST_W-1:0]  s2_dist, s2_gap_err;

  logic [GW-1:0]      gap_raw;
  logic [DIST_W-1:0]  desired_gap, gap_err;
  logic               lead_cons;

  always_comb begin
    gap_raw     = GW'(MIN_GAP) + GW'(TIME_GAP) * GW'(s1_veh);
    desired_gap = (gap_raw > DIST_MAX) ? {DIST_W{1'b1}} : gap_raw[DIST_W-1:0];
    gap_err     = (desired_gap > s1_dist) ? desired_gap - s1_dist : '0;
    lead_cons   = s1_lp && (s1_mode != MODE_OFF) && (s1_mode != MODE_SPEED);
  end

  always_ff @(posedge clk) begin
    s1_mode    <= mode;
    s1_set     <= set_speed;
    s1_veh     <= vehicle_speed;
    s1_lead    <= lead_vehicle_speed;
    s1_lp      <= lead_present;
    s1_dist    <= distance_to_lead;
    s2_off     <= (s1_mode == MODE_OFF);
    s2_lc      <= lead_cons;
    s2_set     <= s1_set;
    s2_veh     <= s1_veh;
    s2_lead    <= s1_lead;
    s2_dist    <= s1_dist;
    s2_gap_err <= gap_err;
  end

  // Stage 3: FSM and ramps
  state_t           cur, nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [OUT_W-1:0] thr_tgt, brk_tgt, thr_new, brk_new;
  logic [MW-1:0]    tgt_w, veh_w, lead_w, closing;
  logic             trig;

  always_comb begin
    nxt      = cur;
    hold_nxt = hold_cnt;
    thr_tgt  = '0;
    brk_tgt  = '0;
    veh_w    = MW'(s2_veh);
    lead_w   = MW'(s2_lead);
    tgt_w    = MW'(s2_set);
    closing  = (veh_w > lead_w) ? veh_w - lead_w : '0;
    trig     = s2_lc && (s2_dist < DIST_W'(EMERG_DIST)) && (s2_veh > s2_lead);

    if (trig) begin
      nxt      = ST_EMERG;
      hold_nxt = HW'(EMERG_HOLD - 1);
    end else if (cur == ST_EMERG && hold_cnt != '0) begin
      hold_nxt = hold_cnt - 1'b1;
    end else if (s2_off) begin
      nxt = ST_IDLE;
    end else if (s2_lc && s2_gap_err != '0) begin
      nxt = ST_BRAKE;
    end else if (s2_lc && s2_lead < s2_set) begin
      nxt = ST_FOLLOW;
    end else begin
      nxt = ST_CRUISE;
    end

    if (nxt == ST_FOLLOW) tgt_w = lead_w;
    case (nxt)
      ST_CRUISE, ST_FOLLOW: begin
        if (tgt_w > veh_w)      thr_tgt = sat((tgt_w - veh_w) << KP_SHIFT);
        else if (veh_w > tgt_w) brk_tgt = sat((veh_w - tgt_w) << KP_SHIFT);
      end
      ST_BRAKE: brk_tgt = sat((MW'(s2_gap_err) << KB_SHIFT) + closing);
      default: ;
    endcase

    // Throttle is cut whenever any braking is commanded or still bleeding off.
    brk_new = (nxt == ST_EMERG) ? OUT_MAX : ramp(brake_out, brk_tgt);
    thr_new = (nxt == ST_EMERG || brk_tgt != '0 || brk_new != '0) ? '0 : ramp(throttle_out, thr_tgt);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      out_valid    <= 1'b0;
      cur          <= ST_IDLE;
      hold_cnt     <= '0;
      throttle_out <= '0;
      brake_out    <= '0;
    end else begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        cur          <= nxt;
        hold_cnt     <= hold_nxt;
        throttle_out <= thr_new;
        brake_out    <= brk_new;
      end
    end
  end

  assign state     = cur;
  assign emergency = (cur == ST_EMERG);

endmodule

`default_nettype wire

// File: tb/tb_acc_ctrl_param.sv
// tb_acc_ctrl_param -- scoreboard bench for acc_ctrl_param using a behavioural reference model.
// Rev 1.0
`default_nettype none

module tb_acc_ctrl_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] set_speed = '0, vehicle_speed = '0, lead_vehicle_speed = '0;
  logic        lead_present = 1'b0;
  logic [15:0] distance_to_lead = '0;
  logic [7:0]  throttle_out, brake_out;
  logic        out_valid;
  logic [2:0]  state;
  logic        emergency;

  acc_ctrl_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
    .set_speed(set_speed), .vehicle_speed(vehicle_speed),
    .lead_vehicle_speed(lead_vehicle_speed), .lead_present(lead_present),
    .distance_to_lead(distance_to_lead), .throttle_out(throttle_out),
    .brake_out(brake_out), .out_valid(out_valid), .state(state), .emergency(emergency)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int thr; int brk; int st; int cyc; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int m_state = 0, m_thr = 0, m_brk = 0, m_hold = 0;
  int last_thr = 0, last_brk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, expv, cyc);
    end
  endtask

  function automatic int satb(input longint x);
    return (x > 255) ? 255 : int'(x);
  endfunction

  function automatic int rampb(input int c, input int t);
    if (t > c) return (t - c <= 8) ? t : c + 8;
    if (c > t) return (c - t <= 8) ? t : c - 8;
    return t;
  endfunction

  task automatic model_reset();
    m_state = 0; m_thr = 0; m_brk = 0; m_hold = 0;
  endtask

  task automatic model_step(input int m, input int s, input int v, input int l, input bit lp, input int d);
    bit lc, trig;
    longint dg, ge;
    int ns, tt, bt, tg;
    lc   = lp && m != 0 && m != 1;
    dg   = 20 + v;
    if (dg > 65535) dg = 65535;
    ge   = (dg > d) ? dg - d : 0;
    trig = lc && d < 15 && v > l;
    if (trig) begin ns = 4; m_hold = 3; end
    else if (m_state == 4 && m_hold > 0) begin ns = 4; m_hold--; end
    else if (m == 0) ns = 0;
    else if (lc && ge > 0) ns = 3;
    else if (lc && l < s) ns = 2;
    else ns = 1;
    tt = 0; bt = 0;
    tg = (ns == 2) ? l : s;
    if (ns == 1 || ns == 2) begin
      if (tg > v) tt = satb(longint'(tg - v) * 4);
      else if (v > tg) bt = satb(longint'(v - tg) * 4);
    end else if (ns == 3) begin
      bt = satb(ge * 2 + ((v > l) ? v - l : 0));
    end
    if (ns == 4) begin
      m_brk = 255; m_thr = 0;
    end else begin
      m_brk = rampb(m_brk, bt);
      m_thr = (bt != 0 || m_brk != 0) ? 0 : rampb(m_thr, tt);
    end
    m_state = ns;
  endtask

  // Drive one sample at posedge+1, record its expected result, return at next posedge+1.
  task automatic send(input int m, input int s, input int v, input int l, input bit lp, input int d);
    exp_t e;
    mode = 2'(m); set_speed = 16'(s); vehicle_speed = 16'(v);
    lead_vehicle_speed = 16'(l); lead_present = lp; distance_to_lead = 16'(d);
    in_valid = 1'b1;
    model_step(m, s, v, l, lp, d);
    e.thr = m_thr; e.brk = m_brk; e.st = m_state; e.cyc = cyc + 3;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      last_thr = 0; last_brk = 0;
    end else if (out_valid) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL stale_out_valid observed=1 expected=0 cyc=%0d", cyc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("throttle", throttle_out, e.thr);
        chk("brake", brake_out, e.brk);
        chk("state", state, e.st);
        chk("emergency", emergency, (e.st == 4) ? 1 : 0);
        chk("exclusive", (throttle_out != 0 && brake_out != 0) ? 1 : 0, 0);
        last_thr = e.thr; last_brk = e.brk;
      end
    end else begin
      chk("hold_thr", throttle_out, last_thr);
      chk("hold_brk", brake_out, last_brk);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_thr", throttle_out, 0);
    chk("rst_brk", brake_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_emerg", emergency, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // Cruise up to throttle 40, then reset with two samples in flight.
    for (int i = 0; i < 5; i++) send(2, 80, 60, 0, 0, 0);
    drain();
    chk("pre_reset_thr", throttle_out, 40);
    send(2, 80, 60, 0, 0, 0);
    send(2, 80, 60, 0, 0, 0);
    reset = 1'b0;
    q.delete();
    model_reset();
    @(posedge clk); @(negedge clk);
    chk("mid_rst_thr", throttle_out, 0);
    chk("mid_rst_brk", brake_out, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_state", state, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; end

    // Cruise from rest: 8,16,...,80 then hold.
    for (int i = 0; i < 12; i++) send(2, 80, 60, 0, 0, 0);
    drain();
    chk("cruise_thr", throttle_out, 80);

    // Follow a slower lead with comfortable gap.
    for (int i = 0; i < 7; i++) send(2, 80, 60, 50, 1, 100);
    drain();
    chk("follow_brk", brake_out, 40);
    chk("follow_state", state, 2);

    // Gap violation brake, then speed-only ignoring the lead.
    for (int i = 0; i < 10; i++) send(2, 80, 60, 50, 1, 50);
    drain();
    chk("gap_brk", brake_out, 70);
    chk("gap_state", state, 3);
    for (int i = 0; i < 20; i++) send(1, 80, 60, 50, 1, 50);
    drain();
    chk("spd_only_thr", throttle_out, 80);
    chk("spd_only_state", state, 1);

    // Emergency entry, hold under mode OFF, then IDLE with brake bleed.
    send(2, 80, 80, 50, 1, 10);
    for (int i = 0; i < 6; i++) send(0, 80, 80, 50, 1, 200);
    drain();
    chk("post_emerg_state", state, 0);
    chk("post_emerg_brk", brake_out, 231);

    // Saturated desired gap and saturated brake target.
    for (int i = 0; i < 35; i++) send(3, 80, 65530, 65530, 1, 60000);
    drain();
    chk("sat_brk", brake_out, 255);
    chk("sat_state", state, 3);

    // Random samples with idle gaps, including emergency re-triggers.
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 3), $urandom_range(0, 120), $urandom_range(0, 120),
           $urandom_range(0, 120), 1'($urandom_range(0, 1)), $urandom_range(0, 150));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
